// File: rtl/stim_sweep.sv
// Self-running exhaustive stimulus sweep (binary or Gray order) with an
// output-change monitor that timestamps events into a first-word-fall-through FIFO.
module stim_sweep #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 2,
  parameter int HOLD       = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int TIME_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [TIME_W-1:0] ev_time,
  output logic [IN_W-1:0]   ev_pattern,
  output logic [OUT_W-1:0]  ev_value,
  output logic [OUT_W-1:0]  ev_mask
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [IN_W-1:0]   pat;
    logic [OUT_W-1:0]  val;
    logic [OUT_W-1:0]  mask;
  } ev_t;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   pat_q, pat_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [TIME_W-1:0] cyc_q, cyc_d;
  logic              mode_q, mode_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic [OUT_W-1:0]  prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W:0]    wr_q, wr_d, rd_q, rd_d;
  ev_t               mem_q [FIFO_DEPTH];
  ev_t               mem_d [FIFO_DEPTH];

  logic run, ev_push, push_ok, pop, full, empty;
  ev_t  ev_new, head;
  logic [IN_W-1:0] pat_nx;

  function automatic logic [IN_W-1:0] order(input logic g, input logic [IN_W-1:0] b);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    mode_d  = mode_q;
    stim_d  = stim_q;
    prev_d  = prev_q;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    pat_nx  = pat_q + IN_W'(1);

    // Monitor: cycle 0 only establishes the baseline sample.
    run     = (state_q == S_RUN);
    ev_new  = '{t: cyc_q, pat: stim_q, val: dut_out, mask: dut_out ^ prev_q};
    ev_push = run && (cyc_q != '0) && (dut_out != prev_q);

    empty   = (wr_q == rd_q);
    full    = ((wr_q ^ rd_q) == {1'b1, {PTR_W{1'b0}}});
    pop     = !empty && ev_ready;
    push_ok = ev_push && (!full || pop);

    if (pop) rd_d = rd_q + (PTR_W+1)'(1);
    if (push_ok) begin
      mem_d[wr_q[PTR_W-1:0]] = ev_new;
      wr_d = wr_q + (PTR_W+1)'(1);
    end
    if (ev_push && !push_ok) ovf_d = 1'b1;

    case (state_q)
      S_RUN: begin
        prev_d = dut_out;
        if (cyc_q != '1) cyc_d = cyc_q + TIME_W'(1);
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (pat_q == '1) begin
            state_d = S_DONE;
          end else begin
            pat_d  = pat_nx;
            stim_d = order(mode_q, pat_nx);
          end
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: begin
        // Accepted start flushes the FIFO; no push can be pending outside RUN.
        if (start) begin
          state_d = S_RUN;
          pat_d   = '0;
          hold_d  = '0;
          cyc_d   = '0;
          mode_d  = mode;
          stim_d  = '0;
          ovf_d   = 1'b0;
          wr_d    = '0;
          rd_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      hold_q  <= '0;
      cyc_q   <= '0;
      mode_q  <= 1'b0;
      stim_q  <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      mode_q  <= mode_d;
      stim_q  <= stim_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head       = mem_q[rd_q[PTR_W-1:0]];
  assign stim       = stim_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign ev_valid   = (wr_q != rd_q);
  assign ev_time    = ev_valid ? head.t    : '0;
  assign ev_pattern = ev_valid ? head.pat  : '0;
  assign ev_value   = ev_valid ? head.val  : '0;
  assign ev_mask    = ev_valid ? head.mask : '0;

endmodule

// File: tb/tb_stim_sweep.sv
// Scoreboard bench for stim_sweep: IN_W=3, OUT_W=2, HOLD=4, FIFO_DEPTH=4, dut_out=stim[1:0].
module tb_stim_sweep;

  localparam int IN_W = 3, OUT_W = 2, HOLD = 4, DEPTH = 4, TIME_W = 16;
  localparam int NCYC = (1 << IN_W) * HOLD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic              ev_ready = 1'b0;
  logic [IN_W-1:0]   stim;
  logic [OUT_W-1:0]  dut_out;
  logic              busy, done, overflow, ev_valid;
  logic [TIME_W-1:0] ev_time;
  logic [IN_W-1:0]   ev_pattern;
  logic [OUT_W-1:0]  ev_value, ev_mask;

  typedef struct {
    int              t;
    logic [IN_W-1:0] pat;
    logic [1:0]      val;
    logic [1:0]      mask;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;
  assign dut_out = stim[1:0];

  stim_sweep #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD(HOLD), .FIFO_DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .overflow(overflow), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_time(ev_time), .ev_pattern(ev_pattern), .ev_value(ev_value), .ev_mask(ev_mask)
  );

  function automatic logic [IN_W-1:0] pat_of(input bit g, input int p);
    logic [IN_W-1:0] b;
    b = IN_W'(p);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({stim, busy, done, overflow, ev_valid} !== '0 || ev_time !== '0) begin
      errors++;
      $display("FAIL reset: stim=%0d busy=%b done=%b ovf=%b ev_valid=%b ev_time=%0d, all required 0",
               stim, busy, done, overflow, ev_valid, ev_time);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, ev_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b ev_valid=%b, required 000", busy, done, ev_valid);
    end
  endtask

  // Starts a sweep, expects the first `keep` model events; later ones are dropped.
  task automatic run_sweep(input bit m, input int ready_from, input int keep,
                           input int start_at, input int ncyc, input string nm);
    int drop_t = -1;
    int nexp = 0;
    logic [1:0] pv, v;
    logic [IN_W-1:0] s, exp_stim;
    exp_t e;
    pv = 2'b00;
    for (int p = 1; p < (1 << IN_W); p++) begin
      s = pat_of(m, p);
      v = s[1:0];
      if (v != pv) begin
        e = '{t: p * HOLD, pat: s, val: v, mask: v ^ pv};
        if (nexp < keep) sb.push_back(e);
        else if (drop_t < 0) drop_t = p * HOLD;
        nexp++;
      end
      pv = v;
    end

    @(negedge clk);
    start = 1'b1; mode = m; ev_ready = 1'b0;
    @(negedge clk);
    mode = ~m;
    for (int c = 0; c < ncyc; c++) begin
      start    = (c == start_at);
      ev_ready = (c >= ready_from);
      exp_stim = (c < NCYC) ? pat_of(m, c / HOLD) : pat_of(m, (1 << IN_W) - 1);
      vectors++;
      if (stim !== exp_stim) begin
        errors++;
        $display("FAIL %s stim c=%0d: got %0d want %0d", nm, c, stim, exp_stim);
      end
      vectors++;
      if (busy !== (c < NCYC) || done !== (c >= NCYC)) begin
        errors++;
        $display("FAIL %s busy/done c=%0d: got %b/%b want %b/%b", nm, c, busy, done, c < NCYC, c >= NCYC);
      end
      vectors++;
      if (overflow !== (drop_t >= 0 && c > drop_t)) begin
        errors++;
        $display("FAIL %s overflow c=%0d: got %b want %b", nm, c, overflow, drop_t >= 0 && c > drop_t);
      end
      if (ev_valid && ev_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected event c=%0d: got t=%0d, none expected", nm, c, ev_time);
        end else begin
          e = sb.pop_front();
          if (ev_time !== TIME_W'(e.t) || ev_pattern !== e.pat || ev_value !== e.val || ev_mask !== e.mask) begin
            errors++;
            $display("FAIL %s event c=%0d: got t=%0d pat=%0d val=%b mask=%b want t=%0d pat=%0d val=%b mask=%b",
                     nm, c, ev_time, ev_pattern, ev_value, ev_mask, e.t, e.pat, e.val, e.mask);
          end
        end
        if (ready_from == 0) begin
          vectors++;
          if (int'(ev_time) !== c - 1) begin
            errors++;
            $display("FAIL %s latency: event t=%0d seen at c=%0d, want c=%0d", nm, ev_time, c, ev_time + 1);
          end
        end
      end else if (!ev_valid) begin
        vectors++;
        if (ev_time !== '0 || ev_pattern !== '0 || ev_value !== '0 || ev_mask !== '0) begin
          errors++;
          $display("FAIL %s idle_data c=%0d: got t=%0d pat=%0d val=%b mask=%b want all 0",
                   nm, c, ev_time, ev_pattern, ev_value, ev_mask);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    ev_ready = 1'b0;
    if (ready_from < ncyc) begin
      vectors++;
      if (sb.size() != 0 || ev_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s drain: %0d expected events left, ev_valid=%b, want 0/0", nm, sb.size(), ev_valid);
      end
    end
  endtask

  task automatic test_binary();      run_sweep(1'b0, 0, 99, -1, NCYC + 4, "binary");        endtask
  task automatic test_gray_ignore(); run_sweep(1'b1, 0, 99, 5, NCYC + 4, "gray_start_ign"); endtask
  task automatic test_overflow();    run_sweep(1'b0, NCYC + 8, DEPTH, -1, NCYC + 16, "overflow"); endtask
  task automatic test_full_pop();    run_sweep(1'b0, 20, 99, -1, NCYC + 12, "full_pop");     endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; ev_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (stim !== 3'd2 || ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre: stim=%0d ev_valid=%b want 2/1", stim, ev_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({stim, busy, done, overflow, ev_valid} !== '0 || ev_time !== '0) begin
      errors++;
      $display("FAIL reset_mid: stim=%0d busy=%b done=%b ovf=%b ev_valid=%b ev_time=%0d want all 0",
               stim, busy, done, overflow, ev_valid, ev_time);
    end
    run_sweep(1'b0, 0, 99, -1, NCYC + 4, "after_reset");
  endtask

  task automatic test_done_restart();
    run_sweep(1'b1, 100000, DEPTH, -1, NCYC + 2, "fill");
    vectors++;
    if (done !== 1'b1 || ev_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL done_restart pre: done=%b ev_valid=%b ovf=%b want 1/1/1", done, ev_valid, overflow);
    end
    sb.delete();
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || ev_valid !== 1'b0 || overflow !== 1'b0 || stim !== '0) begin
      errors++;
      $display("FAIL done_restart: done=%b busy=%b ev_valid=%b ovf=%b stim=%0d want 0/1/0/0/0",
               done, busy, ev_valid, overflow, stim);
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_gray_ignore();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_done_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/stim_sweep.md
# stim_sweep

Parametrised self-running stimulus generator and output-change monitor for exhaustive checking of small combinational blocks. It drives every `IN_W`-bit input pattern in binary or Gray order, holding each pattern for `HOLD` cycles. It timestamps every change on the observed DUT outputs and queues those changes in an event FIFO. It replaces free-running toggle stimulus and `$display` change logging with a synthesizable, clocked block usable in benches and on the board.

## Interface
- `IN_W`, default 3: stimulus width; the sweep covers 2^IN_W patterns.
- `OUT_W`, default 2: width of the monitored DUT output.
- `HOLD`, default 20: cycles each pattern is held; must be ≥ 1.
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of 2, ≥ 2.
- `TIME_W`, default 16: timestamp width.

Ports:
- `clk` in 1: the block's single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a sweep; accepted only in IDLE or DONE.
- `mode` in 1: 0 selects binary order, 1 selects Gray order; sampled on accepted `start`.
- `stim` out IN_W: registered stimulus, driven to the DUT.
- `dut_out` in OUT_W: DUT output under observation.
- `busy` out 1: high while in RUN.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; at least one event was dropped.
- `ev_valid` out 1: FIFO non-empty.
- `ev_ready` in 1: consumer pops the head entry when `ev_valid && ev_ready`.
- `ev_time` out TIME_W: cycle index of the event.
- `ev_pattern` out IN_W: `stim` value during the event cycle.
- `ev_value` out OUT_W: new `dut_out` value.
- `ev_mask` out OUT_W: XOR of the new and previous `dut_out` values; never zero.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE→RUN on `start`. DONE→RUN on `start`. RUN→DONE after the last hold cycle of pattern 2^IN_W−1. `start` during RUN is ignored.
- Accepted `start` effects:
  - pattern index, hold counter and cycle counter are cleared;
  - `mode` is latched;
  - the FIFO is flushed;
  - `overflow` and `done` are cleared.
- Cycle c counts from 0, the first RUN cycle. Pattern index p is driven during cycles p·HOLD … p·HOLD+HOLD−1.
- `stim` equals p in binary mode and p ^ (p>>1) in Gray mode.
- Cycle counter arithmetic: `ev_time` is c, saturating at 2^TIME_W−1.
- The monitor samples `dut_out` every RUN cycle. The cycle-0 sample is the baseline and never produces an event.
- For c ≥ 1, a sample that differs from the cycle c−1 sample pushes {c, stim, dut_out, mask}. The push is registered at the end of cycle c.
- No sampling or events occur in IDLE or DONE. `stim` holds its last pattern in DONE.
- FIFO push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Otherwise the event is dropped and `overflow` is set from the next cycle. Pops remain allowed in every state.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `overflow`=0, `ev_valid`=0, FIFO empty. Event data outputs are 0 while `ev_valid`=0.
- `start` at edge k: `busy`=1 and `stim`=first pattern from edge k on, so cycle 0 is the cycle after `start` is sampled.
- `stim` updates at edge p·HOLD, when the hold counter wraps from HOLD−1.
- Event latency: an event detected in cycle c gives `ev_valid`=1 in cycle c+1 if the FIFO was empty. The FIFO is first-word-fall-through, so head data is valid while `ev_valid`=1.
- DONE is entered at cycle 2^IN_W·HOLD: `busy`=0 and `done`=1 from that cycle.
- `reset` asserted mid-sweep: all reset values apply from the next cycle, and pending events are discarded.
- With HOLD=1, every cycle is a new pattern; the monitor must still compare consecutive cycles without gaps.

## Test plan
- IN_W=3, OUT_W=2, HOLD=4, binary mode, `dut_out`=`stim[1:0]`, `ev_ready`=1:
  - 7 events at c=4,8,…,28;
  - masks are 01,11,01,11,01,11,01;
  - `done` rises at c=32.
- Same bench in Gray mode:
  - 6 events at c=4,8,12,20,24,28;
  - masks are 01,10,01,01,10,01;
  - no event at c=16.
- Same bench with FIFO_DEPTH=4 and `ev_ready`=0:
  - 4 entries are stored;
  - the c=20 event is dropped and `overflow`=1 from c=21;
  - draining yields `ev_time` values 4,8,12,16.
- FIFO full with `ev_ready`=1 in the same cycle as the next event: the pop and push both occur, `overflow` stays 0, and order is preserved.
- `reset` asserted at c=10, then `start`:
  - all outputs are at reset values the following cycle;
  - the restarted sweep begins again at `stim`=0 with timestamps from 0.
- `start` pulsed at c=5: ignored. `start` in DONE restarts the sweep with `done` cleared and the FIFO flushed.
